mem_port_arbiter: RTL



---
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing memory port B between the CPU data path (requester 0) and
// the loader/DMA (requester 1). One access per cycle, run-length-limited
// priority so a busy requester cannot starve the other, and read data
// routed back to the issuer one cycle after the grant.
module mem_port_arbiter #(
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    logic             last_gnt_reg, last_gnt_next;
    logic [CNT_W-1:0] run_cnt_reg, run_cnt_next;
    logic             rd_pend_reg, rd_pend_next;
    logic             rd_id_reg, rd_id_next;

    logic             gnt_any;
    logic             winner;
    logic             sel_we;
    logic [1:0]       gnt_vec;
    logic [1:0]       rvalid_vec;
    logic [DATA_W-1:0] rdata_vec [2];

    // Pick the winner for this cycle; reset suppresses every grant.
    always_comb begin
        gnt_any = 1'b0;
        winner  = 1'b0;
        if (!reset) begin
            if (r0_req && r1_req) begin
                gnt_any = 1'b1;
                winner  = (run_cnt_reg < CNT_MAX) ? last_gnt_reg : ~last_gnt_reg;
            end else if (r0_req) begin
                gnt_any = 1'b1;
                winner  = 1'b0;
            end else if (r1_req) begin
                gnt_any = 1'b1;
                winner  = 1'b1;
            end
        end
    end

    // Steer the winner's command onto the memory port; idle port drives zeros.
    always_comb begin
        sel_we   = winner ? r1_we : r0_we;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        if (gnt_any) begin
            mem_we   = sel_we;
            mem_addr = winner ? r1_addr : r0_addr;
            mem_din  = winner ? r1_wdata : r0_wdata;
        end
    end

    // Per-requester grant and read-return decode.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            assign gnt_vec[gi]    = gnt_any && (winner == gi[0]);
            assign rvalid_vec[gi] = rd_pend_reg && (rd_id_reg == gi[0]);
            assign rdata_vec[gi]  = rvalid_vec[gi] ? mem_dout : '0;
        end
    endgenerate

    assign r0_gnt    = gnt_vec[0];
    assign r1_gnt    = gnt_vec[1];
    assign r0_rvalid = rvalid_vec[0];
    assign r1_rvalid = rvalid_vec[1];
    assign r0_rdata  = rdata_vec[0];
    assign r1_rdata  = rdata_vec[1];

    // Run-length bookkeeping and read-return tracking for the next cycle.
    always_comb begin
        last_gnt_next = last_gnt_reg;
        run_cnt_next  = run_cnt_reg;
        rd_pend_next  = 1'b0;
        rd_id_next    = rd_id_reg;
        if (gnt_any) begin
            if (winner == last_gnt_reg) begin
                run_cnt_next = (run_cnt_reg < CNT_MAX) ? run_cnt_reg + 1'b1 : run_cnt_reg;
            end else begin
                last_gnt_next = winner;
                run_cnt_next  = CNT_W'(1);
            end
            rd_pend_next = ~sel_we;
            rd_id_next   = winner;
        end
    end

    // State registers; reset leaves requester 1 "saturated" so requester 0
    // wins the first contested cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt_reg <= 1'b1;
            run_cnt_reg  <= CNT_MAX;
            rd_pend_reg  <= 1'b0;
            rd_id_reg    <= 1'b0;
        end else begin
            last_gnt_reg <= last_gnt_next;
            run_cnt_reg  <= run_cnt_next;
            rd_pend_reg  <= rd_pend_next;
            rd_id_reg    <= rd_id_next;
        end
    end

endmodule
